mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage between the execute stage and the writeback stage.
- Holds one instruction and waits for the data-SRAM response when that instruction issued a load or store in EX.
- Extracts and sign- or zero-extends load data, then hands pc, destination, result and exception flag to writeback.
- Drops responses that belong to instructions cancelled by a writeback flush, so a late data_ok is never attributed to the wrong instruction.

Parameters:
- (none): all widths are fixed at 32-bit data/address and 5-bit register index.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
es_to_ms_valid  in  1  EX holds a valid instruction for MEM
ms_allowin  out  1  MEM accepts a new instruction this cycle
es_pc  in  32  instruction pc
es_gr_we  in  1  instruction writes a GPR
es_dest  in  5  destination GPR
es_alu_result  in  32  ALU result; memory address when es_mem_req=1
es_res_from_mem  in  1  result comes from the load data
es_mem_req  in  1  EX issued a data-SRAM request (load or store) that was accepted (addr_ok seen)
es_ld_op  in  3  load type: 0=W, 1=B, 2=BU, 3=H, 4=HU
es_exc  in  1  an exception is already flagged upstream
data_sram_data_ok  in  1  data-SRAM response strobe, one per accepted request, in order
data_sram_rdata  in  32  response data, valid with data_ok
flush  in  1  writeback exception / ertn / refetch flush
ws_allowin  in  1  writeback accepts
ms_to_ws_valid  out  1  MEM output valid
ms_pc  out  32  latched pc
ms_gr_we  out  1  latched gr_we, forced 0 when ms_exc=1
ms_dest  out  5  latched dest
ms_final_result  out  32  load data or ALU result
ms_exc  out  1  latched es_exc
ms_fwd_blk  out  1  ms_valid & res_from_mem & waiting; the decode stage must stall on a dest match

Behaviour:
- Reset: ms_valid=0, wait_resp=0, cancel_cnt=0, all latched fields=0. Consequently ms_to_ws_valid=0, ms_fwd_blk=0, ms_allowin=1.
- Ready and allow-in:
  - ms_ready_go = !wait_resp.
  - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
  - ms_to_ws_valid = ms_valid & ms_ready_go & !flush.
- Accept: on ms_allowin & es_to_ms_valid & !flush, latch all es_* fields, set ms_valid=1 and set wait_resp = es_mem_req & !es_exc.
  - If ms_allowin=1 without es_to_ms_valid, ms_valid goes to 0.
- Response attribution: on data_sram_data_ok:
  - If cancel_cnt != 0, decrement cancel_cnt and discard the data.
  - Otherwise, if wait_resp=1, capture rdata into rdata_r and clear wait_resp.
  - A data_ok with cancel_cnt=0 and wait_resp=0 is ignored.
- Load extract: the byte lane is addr[1:0] of the latched address.
  - B/BU: select rdata_r[8*a+7:8*a], then sign- or zero-extend.
  - H/HU: select the half indexed by addr[1]; addr[0] is ignored (misalignment is already an exception upstream).
  - W: pass rdata_r through.
- Final result: ms_final_result = res_from_mem ? extracted data : alu_result. For a store, the response is consumed and the result is the ALU result.
- Flush: in the flush cycle, set ms_valid=0 and wait_resp=0 and accept nothing.
  - cancel_cnt increments by (wait_resp & ms_valid & !data_ok_this_cycle) + (es_to_ms_valid & es_mem_req & ms_allowin).
  - The second term covers an EX request that is in flight but never accepted into MEM.
  - cancel_cnt is 2 bits and saturates at 3; it can never underflow.
- Simultaneous events:
  - data_ok and flush in the same cycle: the response is consumed by the current (flushed) instruction and cancel_cnt is not incremented for it.
  - data_ok and accept in the same cycle: the response belongs to the old instruction; the new instruction's wait_resp is set as normal.
- Reset mid-operation: all state, including cancel_cnt, returns to reset values. The SRAM side is reset by the same signal.

Optional Feature:
- Macro: MS_STALL_CNT_EN.
- Defined:
  - Adds output ms_stall_cnt (32 bits), reset to 0.
  - Increments by 1 each cycle ms_valid & wait_resp, and wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- LD.B, addr 0x1003, data_ok after 3 cycles with rdata=0x80FF1234 -> ms_to_ws_valid rises in the data_ok cycle+1, ms_final_result=0xFFFFFF80, ms_fwd_blk=1 for 3 cycles.
- LD.HU, addr 0x2002, rdata=0xBEEF0000 -> result 0x0000BEEF; LD.H with the same inputs -> 0xFFFFBEEF; LD.W -> 0xBEEF0000.
- ALU op pc=0x1c000004, result 0x55, ws_allowin=0 for 2 cycles -> outputs held stable, ms_allowin=0, then one transfer.
- Load waiting, flush asserted, data_ok 2 cycles later with 0xDEAD, next load's data_ok with 0x00000007 -> the 0xDEAD response is discarded, the next LD.W returns 7, cancel_cnt ends at 0.
- Instruction with es_exc=1 and es_mem_req=1 -> wait_resp=0, passes in 1 cycle, ms_exc=1, ms_gr_we=0.
- MS_STALL_CNT_EN defined, two loads each with 4 wait cycles -> ms_stall_cnt=8; reset -> 0.

Source files
------------

// File: rtl/mem_stage_if.sv
// mem_stage_if: pipeline and data-SRAM response signals of the MEM stage.
// The slave modport is the MEM stage itself; the master modport is its
// environment (EX, data SRAM, WB). Optional macro MS_STALL_CNT_EN adds the
// ms_stall_cnt output.
interface mem_stage_if;
  // EX -> MEM
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic        es_gr_we;
  logic [4:0]  es_dest;
  logic [31:0] es_alu_result;
  logic        es_res_from_mem;
  logic        es_mem_req;
  logic [2:0]  es_ld_op;
  logic        es_exc;
  // data-SRAM response
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  // WB -> MEM control
  logic        flush;
  logic        ws_allowin;
  // MEM -> WB / decode
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_final_result;
  logic        ms_exc;
  logic        ms_fwd_blk;
`ifdef MS_STALL_CNT_EN
  logic [31:0] ms_stall_cnt;
`endif

  modport slave (
    input  es_to_ms_valid, es_pc, es_gr_we, es_dest, es_alu_result,
           es_res_from_mem, es_mem_req, es_ld_op, es_exc,
           data_sram_data_ok, data_sram_rdata, flush, ws_allowin,
    output ms_allowin, ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest,
           ms_final_result, ms_exc, ms_fwd_blk
`ifdef MS_STALL_CNT_EN
    , output ms_stall_cnt
`endif
  );

  modport master (
    output es_to_ms_valid, es_pc, es_gr_we, es_dest, es_alu_result,
           es_res_from_mem, es_mem_req, es_ld_op, es_exc,
           data_sram_data_ok, data_sram_rdata, flush, ws_allowin,
    input  ms_allowin, ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest,
           ms_final_result, ms_exc, ms_fwd_blk
`ifdef MS_STALL_CNT_EN
    , input ms_stall_cnt
`endif
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between EX and WB. Holds one instruction,
// waits for its data-SRAM response, extracts/extends load data and hands the
// result to WB. Responses belonging to flushed instructions are counted in
// cancel_cnt and dropped when they arrive.
// Optional macro MS_STALL_CNT_EN: adds a 32-bit wrapping count of cycles
// spent holding an instruction that still waits for its response.
module mem_stage (
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave bus
);

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_op_e;

  // Stage state
  logic        ms_valid;
  logic        wait_resp;
  logic [1:0]  cancel_cnt;

  // Latched instruction fields
  logic [31:0] pc_r;
  logic        gr_we_r;
  logic [4:0]  dest_r;
  logic [31:0] alu_r;
  logic        res_from_mem_r;
  ld_op_e      ld_op_r;
  logic        exc_r;
  logic [31:0] rdata_r;

  // Combinational helpers
  logic        ms_ready_go;
  logic        allowin;
  logic        accept;
  logic        resp_drop;
  logic        resp_take;
  logic [2:0]  cancel_sum;
  logic [1:0]  cancel_cnt_nxt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Handshake and response attribution for the current cycle.
  always_comb begin
    ms_ready_go = !wait_resp;
    allowin     = !ms_valid || (ms_ready_go && bus.ws_allowin);
    accept      = allowin && bus.es_to_ms_valid && !bus.flush;
    // Outstanding cancelled responses are older than ours, so they go first.
    resp_drop   = bus.data_sram_data_ok && (cancel_cnt != 2'd0);
    resp_take   = bus.data_sram_data_ok && (cancel_cnt == 2'd0) && wait_resp;
  end

  // Next cancel count: drop one on a discarded response, and on a flush add
  // every request whose response is still to come.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cancel_sum = {1'b0, cancel_cnt} - {2'b00, resp_drop};
    if (bus.flush) begin
      // The held instruction's response is only "consumed" when it is the one
      // arriving now; a cancelled response arriving now leaves ours pending.
      cancel_sum = cancel_sum
                 + {2'b00, ms_valid && wait_resp && !resp_take}
                 + {2'b00, bus.es_to_ms_valid && bus.es_mem_req && allowin};
    end
    cancel_cnt_nxt = (cancel_sum > 3'd3) ? 2'd3 : cancel_sum[1:0];
  end

  // Stage registers: valid/wait tracking, cancel count, latched fields.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      ms_valid       <= 1'b0;
      wait_resp      <= 1'b0;
      cancel_cnt     <= 2'd0;
      pc_r           <= 32'd0;
      gr_we_r        <= 1'b0;
      dest_r         <= 5'd0;
      alu_r          <= 32'd0;
      res_from_mem_r <= 1'b0;
      ld_op_r        <= LD_W;
      exc_r          <= 1'b0;
      rdata_r        <= 32'd0;
    end else begin
      cancel_cnt <= cancel_cnt_nxt;

      if (bus.flush) begin
        ms_valid <= 1'b0;
      end else if (allowin) begin
        ms_valid <= bus.es_to_ms_valid;
      end

      if (bus.flush) begin
        wait_resp <= 1'b0;
      end else if (accept) begin
        wait_resp <= bus.es_mem_req && !bus.es_exc;
      end else if (resp_take) begin
        wait_resp <= 1'b0;
      end

      if (resp_take) begin
        rdata_r <= bus.data_sram_rdata;
      end

      if (accept) begin
        pc_r           <= bus.es_pc;
        gr_we_r        <= bus.es_gr_we;
        dest_r         <= bus.es_dest;
        alu_r          <= bus.es_alu_result;
        res_from_mem_r <= bus.es_res_from_mem;
        ld_op_r        <= ld_op_e'(bus.es_ld_op);
        exc_r          <= bus.es_exc;
      end
    end
  end

  // Load data extraction from the captured response and the address lane.
  always_comb begin
    case (alu_r[1:0])
      2'd0:    ld_byte = rdata_r[7:0];
      2'd1:    ld_byte = rdata_r[15:8];
      2'd2:    ld_byte = rdata_r[23:16];
      default: ld_byte = rdata_r[31:24];
    endcase
    // Half loads ignore addr[0]; a misaligned half is flagged upstream.
    ld_half = alu_r[1] ? rdata_r[31:16] : rdata_r[15:0];
    case (ld_op_r)
      LD_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   ld_data = {24'd0, ld_byte};
      LD_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      LD_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = rdata_r;
    endcase
  end

  assign bus.ms_allowin      = allowin;
  assign bus.ms_to_ws_valid  = ms_valid && ms_ready_go && !bus.flush;
  assign bus.ms_pc           = pc_r;
  assign bus.ms_gr_we        = gr_we_r && !exc_r;
  assign bus.ms_dest         = dest_r;
  assign bus.ms_final_result = res_from_mem_r ? ld_data : alu_r;
  assign bus.ms_exc          = exc_r;
  assign bus.ms_fwd_blk      = ms_valid && res_from_mem_r && wait_resp;

`ifdef MS_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // Count cycles spent holding an instruction that waits for its response.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (ms_valid && wait_resp) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.ms_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized bench for mem_stage with a scoreboard. A driver
// models EX, the data SRAM and WB at transaction level; a monitor compares
// every MEM->WB transfer against the expected queue.
module tb_mem_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic        rfm;
    logic        mem_req;
    logic [2:0]  ld_op;
    logic        exc;
    logic [31:0] rdata;
    int          lat;
  } inst_t;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    bit          cancelled;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        exc;
  } exp_t;

  inst_t feed_q[$];
  req_t  sram_q[$];
  exp_t  exp_q[$];

  int checks = 0;
  int errors = 0;

  bit    ex_valid = 1'b0;
  inst_t ex;
  bit    mem_occupied = 1'b0;
  bit    mem_needs_resp = 1'b0;
  bit    mem_resp_done = 1'b0;
  bit    mem_rfm = 1'b0;
  bit    in_reset = 1'b1;
  int unsigned stall_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load result from the architectural rules.
  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [31:0] a,
                                           input logic [2:0] op);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * a[1:0])) & 32'hFF;
    h = (d >> (a[1] ? 16 : 0)) & 32'hFFFF;
    case (op)
      3'd1:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return h;
      default: return d;
    endcase
  endfunction

  function automatic inst_t mk(input logic [31:0] pc, input logic [31:0] alu, input logic rfm,
                               input logic mem_req, input logic [2:0] op, input logic exc,
                               input logic [31:0] rdata, input int lat);
    inst_t i;
    i.pc = pc; i.gr_we = 1'b1; i.dest = 5'(pc[6:2]); i.alu = alu; i.rfm = rfm;
    i.mem_req = mem_req; i.ld_op = op; i.exc = exc; i.rdata = rdata; i.lat = lat;
    return i;
  endfunction

  function automatic inst_t rand_inst();
    inst_t i;
    i = mk($urandom, $urandom, 1'b0, 1'b0, 3'($urandom), 1'b0, $urandom, int'($urandom % 4));
    i.dest  = 5'($urandom);
    i.gr_we = 1'($urandom);
    case ($urandom % 4)
      1: begin i.rfm = 1'b1; i.mem_req = 1'b1; i.gr_we = 1'b1; i.ld_op = 3'($urandom % 5); end
      2: begin i.mem_req = 1'b1; i.gr_we = 1'b0; end
      3: begin i.exc = 1'b1; i.mem_req = 1'($urandom); end
      default: ;
    endcase
    return i;
  endfunction

  function automatic int n_cancelled();
    int n = 0;
    foreach (sram_q[k]) if (sram_q[k].cancelled) n++;
    return n;
  endfunction

  function automatic bit idle();
    return !ex_valid && feed_q.size() == 0 && !mem_occupied && sram_q.size() == 0;
  endfunction

  task automatic drive_es_random();
    bus.es_pc           = $urandom;
    bus.es_gr_we        = 1'($urandom);
    bus.es_dest         = 5'($urandom);
    bus.es_alu_result   = $urandom;
    bus.es_res_from_mem = 1'($urandom);
    bus.es_mem_req      = 1'($urandom);
    bus.es_ld_op        = 3'($urandom);
    bus.es_exc          = 1'($urandom);
  endtask

  task automatic drive_reset();
    @(negedge clk);
    in_reset = 1'b1;
    reset = 1'b1;
    bus.es_to_ms_valid = 1'b0;
    drive_es_random();
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata = 32'd0;
    bus.flush = 1'b0;
    bus.ws_allowin = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    feed_q.delete(); sram_q.delete(); exp_q.delete();
    ex_valid = 1'b0; mem_occupied = 1'b0; mem_needs_resp = 1'b0;
    mem_resp_done = 1'b0; mem_rfm = 1'b0; stall_model = 0;
    in_reset = 1'b0;
    #1;
    check("reset_to_ws_valid", bus.ms_to_ws_valid, 0);
    check("reset_fwd_blk", bus.ms_fwd_blk, 0);
    check("reset_allowin", bus.ms_allowin, 1);
  endtask

  // One clock cycle of the environment: drive at negedge, check, update model.
  task automatic cycle(input bit flush_req, input bit ws);
    bit    d_ok, take_flush, acc, issue, xfer, waiting;
    req_t  r;
    exp_t  e;
    @(negedge clk);
    if (!ex_valid && feed_q.size() != 0) begin
      ex = feed_q.pop_front();
      ex_valid = 1'b1;
    end
    bus.es_to_ms_valid = ex_valid;
    if (ex_valid) begin
      bus.es_pc = ex.pc; bus.es_gr_we = ex.gr_we; bus.es_dest = ex.dest;
      bus.es_alu_result = ex.alu; bus.es_res_from_mem = ex.rfm;
      bus.es_mem_req = ex.mem_req; bus.es_ld_op = ex.ld_op; bus.es_exc = ex.exc;
    end else begin
      drive_es_random();
    end
    d_ok = 1'b0;
    if (sram_q.size() != 0) begin
      if (sram_q[0].lat == 0) d_ok = 1'b1;
      else sram_q[0].lat = sram_q[0].lat - 1;
    end
    bus.data_sram_data_ok = d_ok;
    bus.data_sram_rdata = d_ok ? sram_q[0].rdata : $urandom;
    bus.ws_allowin = ws;
    bus.flush = 1'b0;
    #1;
    waiting = mem_occupied && mem_needs_resp && !mem_resp_done;
    check("ms_allowin", bus.ms_allowin, !mem_occupied || (!waiting && ws));
    check("ms_fwd_blk", bus.ms_fwd_blk, waiting && mem_rfm);
`ifdef MS_STALL_CNT_EN
    check("ms_stall_cnt", bus.ms_stall_cnt, stall_model);
`endif
    // Keep cancelled responses within what a 2-bit count can represent, and
    // never flush an exception-flagged mem_req that issued no real request.
    take_flush = flush_req && !(ex_valid && ex.exc && ex.mem_req) && n_cancelled() <= 1;
    bus.flush = take_flush;
    #2;
    check("ms_to_ws_valid", bus.ms_to_ws_valid, mem_occupied && !waiting && !take_flush);
    acc   = ex_valid && bus.ms_allowin && !take_flush;
    issue = ex_valid && bus.ms_allowin && ex.mem_req && !ex.exc;
    xfer  = mem_occupied && !waiting && !take_flush && ws;
    if (waiting) stall_model++;
    if (d_ok) begin
      r = sram_q.pop_front();
      if (!r.cancelled) mem_resp_done = 1'b1;
    end
    if (take_flush) begin
      if (mem_occupied) begin
        void'(exp_q.pop_front());
        if (mem_needs_resp && !mem_resp_done) begin
          foreach (sram_q[k]) if (!sram_q[k].cancelled) sram_q[k].cancelled = 1'b1;
        end
      end
      if (issue) sram_q.push_back('{rdata: ex.rdata, lat: ex.lat, cancelled: 1'b1});
      mem_occupied = 1'b0;
      ex_valid = 1'b0;
    end else begin
      if (xfer) mem_occupied = 1'b0;
      if (acc) begin
        e.pc = ex.pc; e.gr_we = ex.gr_we && !ex.exc; e.dest = ex.dest; e.exc = ex.exc;
        e.result = ex.rfm ? ref_load(ex.rdata, ex.alu, ex.ld_op) : ex.alu;
        exp_q.push_back(e);
        mem_occupied = 1'b1;
        mem_needs_resp = ex.mem_req && !ex.exc;
        mem_resp_done = 1'b0;
        mem_rfm = ex.rfm;
        if (issue) sram_q.push_back('{rdata: ex.rdata, lat: ex.lat, cancelled: 1'b0});
        ex_valid = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (!idle() && n < 300) begin
      cycle(1'b0, 1'b1);
      n++;
    end
    check("drain_idle", 32'(idle()), 1);
  endtask

  // Monitor: compare each MEM->WB transfer with the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!in_reset && bus.ms_to_ws_valid && bus.ws_allowin) begin
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("ms_pc", bus.ms_pc, e.pc);
          check("ms_final_result", bus.ms_final_result, e.result);
          check("ms_gr_we_dest_exc", {bus.ms_gr_we, bus.ms_dest, bus.ms_exc},
                {e.gr_we, e.dest, e.exc});
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_reset();

    // LD.B from byte 3 of 0x80FF1234: response three cycles after acceptance.
    feed_q.push_back(mk(32'h1c000000, 32'h1003, 1'b1, 1'b1, 3'd1, 1'b0, 32'h80FF1234, 2));
    drain();

    // Half and word loads on the same response word.
    feed_q.push_back(mk(32'h1c000010, 32'h2002, 1'b1, 1'b1, 3'd4, 1'b0, 32'hBEEF0000, 1));
    feed_q.push_back(mk(32'h1c000014, 32'h2002, 1'b1, 1'b1, 3'd3, 1'b0, 32'hBEEF0000, 0));
    feed_q.push_back(mk(32'h1c000018, 32'h2000, 1'b1, 1'b1, 3'd0, 1'b0, 32'hBEEF0000, 3));
    drain();

    // ALU op held while WB stalls for two cycles.
    feed_q.push_back(mk(32'h1c000004, 32'h55, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 0));
    cycle(1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0);
      check("hold_pc", bus.ms_pc, 32'h1c000004);
      check("hold_result", bus.ms_final_result, 32'h55);
      check("hold_allowin", bus.ms_allowin, 0);
    end
    drain();

    // Flush while a load waits; its late 0xDEAD response must be dropped.
    feed_q.push_back(mk(32'h1c000020, 32'h3000, 1'b1, 1'b1, 3'd0, 1'b0, 32'h0000DEAD, 3));
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    feed_q.push_back(mk(32'h1c000024, 32'h3004, 1'b1, 1'b1, 3'd0, 1'b0, 32'h00000007, 2));
    drain();

    // Exception-flagged memory op passes straight through.
    feed_q.push_back(mk(32'h1c000030, 32'h4000, 1'b0, 1'b1, 3'd0, 1'b1, 32'd0, 0));
    drain();

    // Randomized traffic with WB back-pressure and occasional flushes.
    for (int c = 0; c < 600; c++) begin
      if (feed_q.size() == 0 && ($urandom % 3) != 0) feed_q.push_back(rand_inst());
      cycle(($urandom % 16) == 0, ($urandom % 4) != 0);
    end
    drain();

    // Reset with a cancelled response outstanding: cancel_cnt must clear.
    feed_q.push_back(mk(32'h1c000040, 32'h5000, 1'b1, 1'b1, 3'd0, 1'b0, 32'h0BAD0BAD, 3));
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    drive_reset();
    feed_q.push_back(mk(32'h1c000044, 32'h5004, 1'b1, 1'b1, 3'd2, 1'b0, 32'h00001234, 1));
    drain();

`ifdef MS_STALL_CNT_EN
    drive_reset();
    feed_q.push_back(mk(32'h1c000050, 32'h6000, 1'b1, 1'b1, 3'd0, 1'b0, 32'h11111111, 3));
    feed_q.push_back(mk(32'h1c000054, 32'h6004, 1'b1, 1'b1, 3'd0, 1'b0, 32'h22222222, 3));
    drain();
    check("stall_cnt_two_loads", bus.ms_stall_cnt, 32'd8);
    drive_reset();
    check("stall_cnt_reset", bus.ms_stall_cnt, 32'd0);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
